// File: rtl/rtlola_event_queue.sv
// Input-event buffer between the monitor's raw input ports and the low-level controller.
// Cycles with any fresh input are timestamped and queued; the LLC pops them one per request.
module rtlola_event_queue #(
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_IN*DATA_W-1:0]   in_data,
  input  logic [NUM_IN-1:0]          new_input,
  input  logic                       pop,
  output logic [NUM_IN*DATA_W-1:0]   out_data,
  output logic [NUM_IN-1:0]          out_mask,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       q_push_valid,
  output logic                       q_pop_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [15:0]                drop_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [TAG_W-1:0]         tag_q;
  logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]          count_q, count_d;
  logic [NUM_IN*DATA_W-1:0] data_mem_q [DEPTH];
  logic [NUM_IN-1:0]        mask_mem_q [DEPTH];
  logic [TAG_W-1:0]         tag_mem_q  [DEPTH];
  logic [NUM_IN*DATA_W-1:0] out_data_q;
  logic [NUM_IN-1:0]        out_mask_q;
  logic [TAG_W-1:0]         out_tag_q;
  logic                     push_valid_q, pop_valid_q, overflow_q;
  logic [15:0]              drop_count_q;

  logic ev, full_w, empty_w, pop_acc, push_acc, drop;

  always_comb begin
    full_w   = (count_q == CntW'(DEPTH));
    empty_w  = (count_q == '0);
    ev       = en & (|new_input);
    pop_acc  = en & pop & ~empty_w;
    // A pop frees the head slot in the same cycle, so a full queue can still accept.
    push_acc = ev & (~full_w | pop_acc);
    drop     = ev & ~push_acc;
    count_d  = count_q;
    if (push_acc && !pop_acc) begin
      count_d = count_q + CntW'(1);
    end else if (!push_acc && pop_acc) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_data_q   <= '0;
      out_mask_q   <= '0;
      out_tag_q    <= '0;
      push_valid_q <= 1'b0;
      pop_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      push_valid_q <= push_acc;
      pop_valid_q  <= pop_acc;
      count_q      <= count_d;
      if (en) begin
        tag_q <= tag_q + TAG_W'(1);
      end
      if (push_acc) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop_acc) begin
        rd_ptr_q   <= rd_ptr_q + PtrW'(1);
        out_data_q <= data_mem_q[rd_ptr_q];
        out_mask_q <= mask_mem_q[rd_ptr_q];
        out_tag_q  <= tag_mem_q[rd_ptr_q];
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != 16'hFFFF) begin
          drop_count_q <= drop_count_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_mem_q[i] <= '0;
        mask_mem_q[i] <= '0;
        tag_mem_q[i]  <= '0;
      end
    end else if (push_acc) begin
      data_mem_q[wr_ptr_q] <= in_data;
      mask_mem_q[wr_ptr_q] <= new_input;
      tag_mem_q[wr_ptr_q]  <= tag_q;
    end
  end

  assign out_data     = out_data_q;
  assign out_mask     = out_mask_q;
  assign out_tag      = out_tag_q;
  assign q_push_valid = push_valid_q;
  assign q_pop_valid  = pop_valid_q;
  assign count        = count_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign overflow     = overflow_q;
  assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_rtlola_event_queue.sv
// Directed bench for rtlola_event_queue: a reference model predicts every cycle's outputs
// and a scoreboard queue carries the expected popped entries.
module tb_rtlola_event_queue;

  localparam int unsigned NUM_IN = 2;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned TAG_W  = 64;

  typedef struct packed {
    logic [TAG_W-1:0]         tag;
    logic [NUM_IN*DATA_W-1:0] data;
    logic [NUM_IN-1:0]        mask;
  } ent_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     en = 1'b0;
  logic [NUM_IN*DATA_W-1:0] in_data = '0;
  logic [NUM_IN-1:0]        new_input = '0;
  logic                     pop = 1'b0;
  logic [NUM_IN*DATA_W-1:0] out_data;
  logic [NUM_IN-1:0]        out_mask;
  logic [TAG_W-1:0]         out_tag;
  logic                     q_push_valid, q_pop_valid, full, empty, overflow;
  logic [$clog2(DEPTH):0]   count;
  logic [15:0]              drop_count;

  rtlola_event_queue #(
    .NUM_IN(NUM_IN), .DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .in_data(in_data), .new_input(new_input), .pop(pop),
    .out_data(out_data), .out_mask(out_mask), .out_tag(out_tag),
    .q_push_valid(q_push_valid), .q_pop_valid(q_pop_valid), .count(count), .full(full),
    .empty(empty), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  ent_t sb[$];
  ent_t last;
  logic [TAG_W-1:0] mtag;
  int   mcount;
  logic mover;
  logic [15:0] mdrop;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic chk_all(input logic pu, input logic pa);
    chk("q_push_valid", 128'(q_push_valid), 128'(pu));
    chk("q_pop_valid", 128'(q_pop_valid), 128'(pa));
    chk("count", 128'(count), 128'(mcount));
    chk("full", 128'(full), 128'(mcount == int'(DEPTH)));
    chk("empty", 128'(empty), 128'(mcount == 0));
    chk("overflow", 128'(overflow), 128'(mover));
    chk("drop_count", 128'(drop_count), 128'(mdrop));
    chk("out_tag", 128'(out_tag), 128'(last.tag));
    chk("out_data", out_data, last.data);
    chk("out_mask", 128'(out_mask), 128'(last.mask));
  endtask

  task automatic model_reset();
    sb.delete();
    last   = '0;
    mtag   = '0;
    mcount = 0;
    mover  = 1'b0;
    mdrop  = '0;
  endtask

  // One clock cycle: drive at the negedge, predict, then check 1 time unit after the posedge.
  task automatic step(input logic e, input logic [NUM_IN-1:0] ni,
                      input logic [NUM_IN*DATA_W-1:0] d, input logic p);
    logic pa, pu, dr;
    ent_t ent;
    en = e; new_input = ni; in_data = d; pop = p;
    pa = e && p && (mcount != 0);
    pu = e && (ni != '0) && ((mcount < int'(DEPTH)) || pa);
    dr = e && (ni != '0) && !pu;
    if (pa) last = sb.pop_front();
    if (pu) begin
      ent.tag = mtag; ent.data = d; ent.mask = ni;
      sb.push_back(ent);
    end
    mcount = mcount + int'(pu) - int'(pa);
    if (dr) begin
      mover = 1'b1;
      if (mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
    end
    if (e) mtag = mtag + 1;
    @(posedge clk);
    #1;
    chk_all(pu, pa);
    @(negedge clk);
  endtask

  function automatic logic [127:0] vals(input int c1, input int c0);
    return {64'(c1), 64'(c0)};
  endfunction

  initial begin
    model_reset();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_all(1'b0, 1'b0);
    rst = 1'b1;

    // 1: idle en=1 for 10 cycles; first event carries tag 10
    repeat (10) step(1'b1, 2'b00, '0, 1'b0);
    chk("tag_before_first_event", 128'(mtag), 128'd10);
    step(1'b1, 2'b01, vals(0, 42), 1'b0);
    step(1'b1, 2'b00, '0, 1'b1);
    step(1'b1, 2'b00, '0, 1'b0);

    // 2: event at cycle 500, pop two cycles later
    while (mtag != 500) step(1'b1, 2'b00, '0, 1'b0);
    step(1'b1, 2'b11, vals(1, 1), 1'b0);
    step(1'b1, 2'b00, '0, 1'b0);
    step(1'b1, 2'b00, '0, 1'b1);
    chk("tag500_popped", 128'(out_tag), 128'd500);

    // 3: five pushes into a depth-4 queue, then drain
    for (int v = 1; v <= 5; v++) step(1'b1, 2'b01, vals(0, v), 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 2'b00, '0, 1'b1);
    step(1'b1, 2'b00, '0, 1'b1);

    // 4: push and pop on a full queue
    for (int v = 5; v <= 8; v++) step(1'b1, 2'b10, vals(v, 0), 1'b0);
    step(1'b1, 2'b10, vals(9, 0), 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, 2'b00, '0, 1'b1);
    chk("last_out_is_9", out_data, vals(9, 0));

    // 5: push and pop on an empty queue: push only
    step(1'b1, 2'b01, vals(3, 11), 1'b1);
    step(1'b1, 2'b00, '0, 1'b1);

    // 6: en=0 hold, then asynchronous reset mid-queue
    for (int v = 20; v < 23; v++) step(1'b1, 2'b11, vals(v, v), 1'b0);
    for (int k = 0; k < 20; k++) step(1'b0, 2'(k + 1), vals(k, k), k[0]);
    step(1'b1, 2'b00, '0, 1'b1);
    step(1'b1, 2'b01, vals(0, 77), 1'b0);
    chk("count_before_reset", 128'(count), 128'd3);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk_all(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 2'b01, vals(0, 5), 1'b0);
    step(1'b1, 2'b00, '0, 1'b1);
    chk("tag_after_reset", 128'(out_tag), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
